if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- 2-wide instruction fetch stage; the producer side of the fetch buffer.
- Holds the architectural fetch PC and issues one aligned 8-byte I-memory read per cycle.
- Splits each returned block into up to two instruction slots, with static branch prediction and HALT detection.
- Drives the fetch buffer's if_* inputs and advances the PC only when the fetch buffer asserts fetch_en.

Parameters:
- NUM_SUPER, 2, fetch width; fixed at 2, slot 0 = older instruction.
- RESET_PC, 64'h0, PC loaded on reset.
- HALT_INST, 32'h0000_0000, encoding that stops fetch (call_pal halt).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  1  global stall; when low, all state holds
- fetch_en  input  1  fetch buffer accepted this cycle's valid slots
- rollback_en  input  1  pipeline flush/redirect request
- rollback_pc  input  64  redirect PC, used when rollback_en=1
- Imem2proc_data  input  64  instruction block; [31:0] at addr, [63:32] at addr+4
- Imem_valid  input  1  Imem2proc_data valid this cycle (hit)
- proc2Imem_addr  output  64  {PC[63:3],3'b000}
- if_PC_out  output  NUM_SUPER x 64  PC of each slot
- if_NPC_out  output  NUM_SUPER x 64  slot PC+4
- if_IR_out  output  NUM_SUPER x 32  instruction word per slot
- if_target_out  output  NUM_SUPER x 64  predicted next PC per slot
- if_valid_inst_out  output  NUM_SUPER  per-slot valid
- halted  output  1  state==HALTED

Behaviour:
- State: PC register (64b) and FSM {RUN, HALTED}.
  - reset -> PC=RESET_PC, RUN.
  - Every output is combinational from PC, state and I-memory inputs.
  - After reset all outputs are valid only once Imem_valid=1.
  - if_valid_inst_out must never depend combinationally on fetch_en; the fetch buffer derives fetch_en from it.
- Slot formation in RUN with Imem_valid=1:
  - PC[2]=0: slot0 = data[31:0] at PC; slot1 = data[63:32] at PC+4; candidate valid = 2'b11.
  - PC[2]=1: only slot1 is populated, with data[63:32] at PC; valid = 2'b10.
  - Invalid slots drive PC/NPC/IR/target = 0.
- Prediction per slot, where disp = sign-extended inst[20:0] << 2 and tgt = NPC + disp:
  - Opcode 6'h30 (BR) or 6'h34 (BSR): taken, target = tgt.
  - Opcode 6'h38..6'h3F (conditional): taken iff inst[20]=1 (backward), target = tgt.
  - Otherwise target = NPC.
  - If slot0 is valid and predicted taken, slot1 valid is forced 0.
- HALT: if a valid slot's IR == HALT_INST, that slot stays valid and any younger slot is forced invalid.
- Imem_valid=0 or state HALTED: if_valid_inst_out = 2'b00 and PC holds.
- rollback_en=1: if_valid_inst_out = 2'b00 in that cycle.
- Sequential update, in priority order:
  1. reset.
  2. rollback_en: PC <= rollback_pc, state <= RUN. Applies regardless of en; this also exits HALTED.
  3. en=0: hold.
  4. Otherwise, when fetch_en=1 and any slot is valid:
     - PC <= target of the youngest valid slot, i.e. the predicted-taken target, or aligned+8 for a sequential block.
     - If a valid slot is HALT: state <= HALTED, PC <= that slot's NPC.
  5. Otherwise hold (fetch buffer full, miss, or halted).
- Wrap-around: PC arithmetic is modulo 2^64. PC+4 and +8 past 64'hFFFF_FFFF_FFFF_FFF8 wrap to low addresses with no fault.
- Latency: the block returned in cycle N is presented in cycle N. The redirected PC appears on proc2Imem_addr in cycle N+1.
- Simultaneous events:
  - reset overrides rollback_en.
  - rollback_en overrides fetch_en, HALT and en.
  - HALT in slot0 together with a taken branch in slot0 is impossible (distinct opcodes).

Test Plan:
- Reset, RESET_PC=0, Imem_valid=1, fetch_en=1, no branches -> addr 0x0, 0x8, 0x10 on consecutive cycles; valid=11; PC_out={4,0}, then {0xC,0x8}.
- Misaligned redirect: rollback_en with rollback_pc=0x104 -> next cycle addr=0x100, valid=2'b10, if_PC_out[1]=0x104; following cycle addr=0x108.
- Backward branch: slot0 at 0x200 is BNE (opcode 0x3D) with disp=-4 words -> valid=01, target[0]=0x1F4; next addr=0x1F0 with PC[2]=1.
- Backpressure/miss: fetch_en=0 for 3 cycles, then Imem_valid=0 for 2 cycles -> PC and addr constant throughout and valid=00 during the miss; advances by 8 on the first cycle with both high.
- HALT: slot0=0x0000_0000 at 0x300 -> valid=01, then halted=1 and valid=00 indefinitely; rollback_en with rollback_pc=0x400 -> RUN, addr=0x400.
- Priority: reset and rollback_en high together -> PC=RESET_PC. en=0 with fetch_en=1 -> PC holds.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Purpose:
//   Two-wide instruction fetch stage, the producer side of the fetch buffer.
//   It holds the architectural fetch PC and issues one aligned 8-byte
//   I-memory read per cycle. Each returned block is split into up to two
//   instruction slots (slot 0 = older). The stage applies static branch
//   prediction to each slot and stops fetching at a HALT instruction. The
//   PC only advances when the fetch buffer accepts the slots (fetch_en).
//
// Ports:
//   clock              system clock
//   reset              synchronous, active-high reset
//   en                 global stall; when low, all state holds
//   fetch_en           fetch buffer accepted this cycle's valid slots
//   rollback_en        flush/redirect request, wins over en and fetch_en
//   rollback_pc        redirect PC used with rollback_en
//   Imem2proc_data     8-byte block; [31:0] at addr, [63:32] at addr+4
//   Imem_valid         Imem2proc_data is valid this cycle
//   proc2Imem_addr     8-byte aligned fetch address
//   if_PC_out          per-slot instruction PC
//   if_NPC_out         per-slot PC+4
//   if_IR_out          per-slot instruction word
//   if_target_out      per-slot predicted next PC
//   if_valid_inst_out  per-slot valid
//   halted             fetch has stopped on a HALT instruction
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int          NUM_SUPER = 2,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_INST = 32'h0000_0000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        fetch_en,
    input  logic                        rollback_en,
    input  logic [63:0]                 rollback_pc,
    input  logic [63:0]                 Imem2proc_data,
    input  logic                        Imem_valid,
    output logic [63:0]                 proc2Imem_addr,
    output logic [NUM_SUPER-1:0][63:0]  if_PC_out,
    output logic [NUM_SUPER-1:0][63:0]  if_NPC_out,
    output logic [NUM_SUPER-1:0][31:0]  if_IR_out,
    output logic [NUM_SUPER-1:0][63:0]  if_target_out,
    output logic [NUM_SUPER-1:0]        if_valid_inst_out,
    output logic                        halted
);

    localparam logic [0:0] STATE_RUN    = 1'b0;
    localparam logic [0:0] STATE_HALTED = 1'b1;

    logic [63:0] pc;
    logic [0:0]  state;

    logic [63:0] aligned_pc;
    logic [63:0] slot0_pc, slot1_pc;
    logic [63:0] slot0_npc, slot1_npc;
    logic [31:0] slot0_ir, slot1_ir;
    logic [63:0] slot0_target, slot1_target;
    logic        slot0_taken, slot1_taken;
    logic        slot0_halt, slot1_halt;
    logic        fetch_ok;
    logic        slot0_valid, slot1_valid;
    logic        any_valid;
    logic        go_halt;
    logic [63:0] next_pc;

    // Static prediction: unconditional BR/BSR are always taken, conditional
    // branches are taken only when the displacement is negative (loops).
    function automatic logic predict_taken(input logic [31:0] ir);
        logic [5:0] opcode;
        opcode = ir[31:26];
        predict_taken = (opcode == 6'h30) || (opcode == 6'h34) ||
                        ((opcode[5:3] == 3'b111) && ir[20]);
    endfunction

    // Branch displacement is a word count; shift to bytes and sign extend.
    function automatic logic [63:0] branch_disp(input logic [31:0] ir);
        branch_disp = {{41{ir[20]}}, ir[20:0], 2'b00};
    endfunction

    // Slot formation, prediction and HALT detection. The valid bits are
    // built only from PC, state, rollback and I-memory inputs, never from
    // fetch_en, because the fetch buffer derives fetch_en from them.
    always_comb begin
        aligned_pc   = pc & ~64'h7;
        slot0_pc     = aligned_pc;
        slot1_pc     = aligned_pc + 64'd4;
        slot0_npc    = aligned_pc + 64'd4;
        slot1_npc    = aligned_pc + 64'd8;
        slot0_ir     = Imem2proc_data[31:0];
        slot1_ir     = Imem2proc_data[63:32];

        slot0_taken  = predict_taken(slot0_ir);
        slot1_taken  = predict_taken(slot1_ir);
        slot0_target = slot0_taken ? (slot0_npc + branch_disp(slot0_ir)) : slot0_npc;
        slot1_target = slot1_taken ? (slot1_npc + branch_disp(slot1_ir)) : slot1_npc;
        slot0_halt   = (slot0_ir == HALT_INST);
        slot1_halt   = (slot1_ir == HALT_INST);

        fetch_ok     = (state == STATE_RUN) && Imem_valid && !rollback_en;

        // A PC in the upper half of the block only fetches slot 1.
        slot0_valid  = fetch_ok && !pc[2];
        // A taken branch or HALT in slot 0 kills the younger slot.
        slot1_valid  = fetch_ok && !(slot0_valid && (slot0_taken || slot0_halt));
        any_valid    = slot0_valid || slot1_valid;

        // The youngest valid slot decides where fetch continues; a HALT is
        // never a branch, so its target is already its NPC.
        next_pc      = slot1_valid ? slot1_target : slot0_target;
        go_halt      = (slot0_valid && slot0_halt) || (slot1_valid && slot1_halt);
    end

    // Drive the fetch-buffer interface; invalid slots present all zeros.
    always_comb begin
        proc2Imem_addr    = aligned_pc;
        halted            = (state == STATE_HALTED);
        if_valid_inst_out = '0;
        if_PC_out         = '0;
        if_NPC_out        = '0;
        if_IR_out         = '0;
        if_target_out     = '0;
        if (slot0_valid) begin
            if_valid_inst_out[0] = 1'b1;
            if_PC_out[0]         = slot0_pc;
            if_NPC_out[0]        = slot0_npc;
            if_IR_out[0]         = slot0_ir;
            if_target_out[0]     = slot0_target;
        end
        if (slot1_valid) begin
            if_valid_inst_out[1] = 1'b1;
            if_PC_out[1]         = slot1_pc;
            if_NPC_out[1]        = slot1_npc;
            if_IR_out[1]         = slot1_ir;
            if_target_out[1]     = slot1_target;
        end
    end

    // PC and run/halt state. Rollback is the only way out of HALTED and
    // acts even while the pipeline is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= STATE_RUN;
        end else if (rollback_en) begin
            pc    <= rollback_pc;
            state <= STATE_RUN;
        end else if (en && fetch_en && any_valid) begin
            pc <= next_pc;
            if (go_halt) begin
                state <= STATE_HALTED;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Purpose:
//   Self-checking bench for if_fetch_stage. A table of per-cycle records
//   holds the inputs and the hand-derived outputs for that cycle. Each
//   record is queued when its inputs are driven and compared against the
//   DUT outputs later in the same cycle. A short hand-written sequence
//   then exercises a HALT that persists for several cycles.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] NOP  = 32'h47FF_041F;  // bis r31,r31,r31
    localparam logic [31:0] BNE  = 32'hF41F_FFFC;  // opcode 3D, disp -4 words
    localparam logic [31:0] BR   = 32'hC000_0010;  // opcode 30, disp +16 words
    localparam logic [31:0] BEQ  = 32'hE400_0004;  // opcode 39, disp +4 words
    localparam logic [31:0] BSR  = 32'hD01F_FFFE;  // opcode 34, disp -2 words
    localparam logic [31:0] HLT  = 32'h0000_0000;
    localparam logic [63:0] TOPA = 64'hFFFF_FFFF_FFFF_FFF8;

    logic                clock;
    logic                reset;
    logic                en;
    logic                fetch_en;
    logic                rollback_en;
    logic [63:0]         rollback_pc;
    logic [63:0]         Imem2proc_data;
    logic                Imem_valid;
    logic [63:0]         proc2Imem_addr;
    logic [1:0][63:0]    if_PC_out;
    logic [1:0][63:0]    if_NPC_out;
    logic [1:0][31:0]    if_IR_out;
    logic [1:0][63:0]    if_target_out;
    logic [1:0]          if_valid_inst_out;
    logic                halted;

    typedef struct {
        logic        rst;
        logic        rb;
        logic [63:0] rb_pc;
        logic        en;
        logic        fen;
        logic        imv;
        logic [63:0] data;
        logic        chk;
        logic [63:0] addr;
        logic [1:0]  valid;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic [31:0] ir0;
        logic [31:0] ir1;
        logic [63:0] tgt0;
        logic [63:0] tgt1;
        logic        halt;
    } vec_t;

    vec_t vecs[28];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    if_fetch_stage #(
        .NUM_SUPER (2),
        .RESET_PC  (64'h0),
        .HALT_INST (32'h0000_0000)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .en                (en),
        .fetch_en          (fetch_en),
        .rollback_en       (rollback_en),
        .rollback_pc       (rollback_pc),
        .Imem2proc_data    (Imem2proc_data),
        .Imem_valid        (Imem_valid),
        .proc2Imem_addr    (proc2Imem_addr),
        .if_PC_out         (if_PC_out),
        .if_NPC_out        (if_NPC_out),
        .if_IR_out         (if_IR_out),
        .if_target_out     (if_target_out),
        .if_valid_inst_out (if_valid_inst_out),
        .halted            (halted)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic rst, input logic rb, input logic [63:0] rb_pc,
        input logic e, input logic fen, input logic imv,
        input logic [31:0] hi, input logic [31:0] lo, input logic chk,
        input logic [63:0] addr, input logic [1:0] valid,
        input logic [63:0] pc0, input logic [63:0] pc1,
        input logic [31:0] ir0, input logic [31:0] ir1,
        input logic [63:0] tgt0, input logic [63:0] tgt1, input logic halt);
        vec_t v;
        v.rst = rst;  v.rb = rb;  v.rb_pc = rb_pc;
        v.en = e;     v.fen = fen; v.imv = imv;
        v.data = {hi, lo};
        v.chk = chk;  v.addr = addr; v.valid = valid;
        v.pc0 = pc0;  v.pc1 = pc1;  v.ir0 = ir0;  v.ir1 = ir1;
        v.tgt0 = tgt0; v.tgt1 = tgt1; v.halt = halt;
        return v;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one record's inputs and queue its expected outputs.
    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        rollback_en    = v.rb;
        rollback_pc    = v.rb_pc;
        en             = v.en;
        fetch_en       = v.fen;
        Imem_valid     = v.imv;
        Imem2proc_data = v.data;
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with the settled outputs.
    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        if (!e.chk) return;
        check64("addr",   proc2Imem_addr,            e.addr);
        check64("valid",  64'(if_valid_inst_out),    64'(e.valid));
        check64("pc0",    if_PC_out[0],              e.pc0);
        check64("pc1",    if_PC_out[1],              e.pc1);
        check64("ir0",    64'(if_IR_out[0]),         64'(e.ir0));
        check64("ir1",    64'(if_IR_out[1]),         64'(e.ir1));
        check64("tgt0",   if_target_out[0],          e.tgt0);
        check64("tgt1",   if_target_out[1],          e.tgt1);
        check64("halted", 64'(halted),               64'(e.halt));
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic runStep(input vec_t v);
        @(posedge clock);
        #1;
        applyStimulus(v);
        @(negedge clock);
        checkOutput();
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; fetch_en = 1'b0; rollback_en = 1'b0;
        rollback_pc = '0; Imem2proc_data = '0; Imem_valid = 1'b0;

        //                rst rb rb_pc     en fen imv hi   lo   chk addr      vld pc0       pc1       ir0  ir1  tgt0      tgt1      hlt
        vecs[0]  = mk(1, 0, 64'h0,   1, 1, 1, NOP, NOP, 0, 64'h0,   2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        // Sequential fetch from reset.
        vecs[1]  = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h0,   2'b11, 64'h0,   64'h4,   NOP, NOP, 64'h4,   64'h8,   0);
        vecs[2]  = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h8,   2'b11, 64'h8,   64'hC,   NOP, NOP, 64'hC,   64'h10,  0);
        // Misaligned redirect.
        vecs[3]  = mk(0, 1, 64'h104, 1, 1, 1, NOP, NOP, 1, 64'h10,  2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        vecs[4]  = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h100, 2'b10, 64'h0,   64'h104, 0,   NOP, 64'h0,   64'h108, 0);
        // Backpressure for three cycles, then a two-cycle miss.
        vecs[5]  = mk(0, 0, 64'h0,   1, 0, 1, NOP, NOP, 1, 64'h108, 2'b11, 64'h108, 64'h10C, NOP, NOP, 64'h10C, 64'h110, 0);
        vecs[6]  = mk(0, 0, 64'h0,   1, 0, 1, NOP, NOP, 1, 64'h108, 2'b11, 64'h108, 64'h10C, NOP, NOP, 64'h10C, 64'h110, 0);
        vecs[7]  = mk(0, 0, 64'h0,   1, 0, 1, NOP, NOP, 1, 64'h108, 2'b11, 64'h108, 64'h10C, NOP, NOP, 64'h10C, 64'h110, 0);
        vecs[8]  = mk(0, 0, 64'h0,   1, 1, 0, NOP, NOP, 1, 64'h108, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        vecs[9]  = mk(0, 0, 64'h0,   1, 1, 0, NOP, NOP, 1, 64'h108, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        vecs[10] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h108, 2'b11, 64'h108, 64'h10C, NOP, NOP, 64'h10C, 64'h110, 0);
        // Backward conditional branch in slot 0.
        vecs[11] = mk(0, 1, 64'h200, 1, 1, 1, NOP, NOP, 1, 64'h110, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        vecs[12] = mk(0, 0, 64'h0,   1, 1, 1, NOP, BNE, 1, 64'h200, 2'b01, 64'h200, 64'h0,   BNE, 0,   64'h1F4, 64'h0,   0);
        vecs[13] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h1F0, 2'b10, 64'h0,   64'h1F4, 0,   NOP, 64'h0,   64'h1F8, 0);
        // en=0 with fetch_en=1 holds the PC.
        vecs[14] = mk(0, 0, 64'h0,   0, 1, 1, NOP, NOP, 1, 64'h1F8, 2'b11, 64'h1F8, 64'h1FC, NOP, NOP, 64'h1FC, 64'h200, 0);
        vecs[15] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h1F8, 2'b11, 64'h1F8, 64'h1FC, NOP, NOP, 64'h1FC, 64'h200, 0);
        // HALT in slot 0, then rollback out of HALTED.
        vecs[16] = mk(0, 1, 64'h300, 1, 1, 1, NOP, NOP, 1, 64'h200, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        vecs[17] = mk(0, 0, 64'h0,   1, 1, 1, NOP, HLT, 1, 64'h300, 2'b01, 64'h300, 64'h0,   HLT, 0,   64'h304, 64'h0,   0);
        vecs[18] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h300, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   1);
        vecs[19] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h300, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   1);
        vecs[20] = mk(0, 1, 64'h400, 1, 1, 1, NOP, NOP, 1, 64'h300, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   1);
        // Reset beats a simultaneous rollback.
        vecs[21] = mk(1, 1, 64'h500, 1, 1, 1, NOP, NOP, 1, 64'h400, 2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   0);
        // Taken BR in slot 1, then HALT in slot 1.
        vecs[22] = mk(0, 0, 64'h0,   1, 1, 1, BR,  NOP, 1, 64'h0,   2'b11, 64'h0,   64'h4,   NOP, BR,  64'h4,   64'h48,  0);
        vecs[23] = mk(0, 0, 64'h0,   1, 1, 1, HLT, NOP, 1, 64'h48,  2'b11, 64'h48,  64'h4C,  NOP, HLT, 64'h4C,  64'h50,  0);
        // Wrap-around at the top of the address space.
        vecs[24] = mk(0, 1, TOPA,    1, 1, 1, NOP, NOP, 1, 64'h50,  2'b00, 64'h0,   64'h0,   0,   0,   64'h0,   64'h0,   1);
        vecs[25] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, TOPA,    2'b11, TOPA,    TOPA+4,  NOP, NOP, TOPA+4,  64'h0,   0);
        // Forward conditional not taken in slot 0, BSR taken in slot 1.
        vecs[26] = mk(0, 0, 64'h0,   1, 1, 1, BSR, BEQ, 1, 64'h0,   2'b11, 64'h0,   64'h4,   BEQ, BSR, 64'h4,   64'h0,   0);
        vecs[27] = mk(0, 0, 64'h0,   1, 1, 1, NOP, NOP, 1, 64'h0,   2'b11, 64'h0,   64'h4,   NOP, NOP, 64'h4,   64'h8,   0);

        for (int i = 0; i < 28; i++) begin
            runStep(vecs[i]);
        end

        // HALT in slot 0 at 0x8 must keep fetch stopped for many cycles.
        runStep(mk(0, 0, 64'h0, 1, 1, 1, NOP, HLT, 1, 64'h8, 2'b01, 64'h8, 64'h0, HLT, 0, 64'hC, 64'h0, 0));
        for (int k = 0; k < 5; k++) begin
            runStep(mk(0, 0, 64'h0, 1, 1, 1, NOP, NOP, 1, 64'h8, 2'b00, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 1));
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
